// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam int          DIGIT_W     = 4;
    localparam int          BCD_MAX_DEC = 9999;
    localparam logic [15:0] BCD_INVALID = 16'hFFFF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    output logic [DIGIT_W-1:0] y
);

    always_comb begin
        y = a;
        if (a >= DIGIT_W'(5))
            y = a + DIGIT_W'(3);
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter feeding the seven-segment display register.
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one double-dabble iteration per clock, BIN_W iterations
//   ERR   | input above MAX_VAL; publish the blanking pattern next edge
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = BCD_MAX_DEC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SW    = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t           state;
    logic [SW-1:0]    scratch;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] corr;
    logic [SW-1:0]    scratch_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .a (scratch[BIN_W + DIGIT_W*g +: DIGIT_W]),
            .y (corr[DIGIT_W*g +: DIGIT_W])
        );
    end

    // The shift drops the top bit of the corrected vector; it is always 0 for in-range inputs.
    assign scratch_nxt = {corr, scratch[BIN_W-1:0]} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            scratch  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (bin_in <= MAX_BIN) begin
                            scratch <= {{BCD_W{1'b0}}, bin_in};
                            cnt     <= '0;
                            state   <= SHIFT;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    if (cnt == LAST_CNT) begin
                        cnt      <= '0;
                        bcd_out  <= scratch_nxt[SW-1 -: BCD_W];
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    bcd_out  <= '1;
                    overflow <= 1'b1;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
